rd_ddr_fifo_sched: RTL

Read-burst scheduler that keeps the DDR read FIFO (the frame-buffer-to-display FIFO) topped up. It watches the FIFO write-side water level, issues DDR read bursts with a request/acknowledge handshake, and steers returned beats into the FIFO write port. It walks one frame's address range per `frame_start` and flushes the FIFO at each frame boundary. It sits in the DDR-side clock domain, between the DDR read port and the FIFO write side.

---
 rtl/rd_ddr_fifo_sched.sv | 182 ++++++++++++++++++
 1 files changed

// File: rtl/rd_ddr_fifo_sched.sv
// Read-burst scheduler that keeps the display read FIFO topped up from DDR.
// It walks one frame's address range per frame_start, issues bursts only when
// the FIFO has room for the whole burst, and flushes the FIFO at every frame
// boundary. The FIFO write path is a zero-latency pass-through gated by DATA.
module rd_ddr_fifo_sched #(
  parameter int                    ADDR_WIDTH       = 28,
  parameter int                    DATA_WIDTH       = 256,
  parameter int                    FIFO_DEPTH_WIDTH = 10,
  parameter int                    BURST_LEN        = 64,
  parameter int                    FRAME_BEATS      = 32400,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR        = '0,
  parameter int                    ADDR_STEP        = 32,
  parameter int                    FLUSH_CYCLES     = 8
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      enable,
  input  logic                      frame_start,
  output logic                      ddr_rd_req,
  output logic [ADDR_WIDTH-1:0]     ddr_rd_addr,
  output logic [8:0]                ddr_rd_len,
  input  logic                      ddr_rd_ack,
  input  logic                      ddr_rd_valid,
  input  logic [DATA_WIDTH-1:0]     ddr_rd_data,
  output logic                      fifo_wr_en,
  output logic [DATA_WIDTH-1:0]     fifo_wr_data,
  output logic                      fifo_rst,
  input  logic                      fifo_wr_full,
  input  logic [FIFO_DEPTH_WIDTH:0] fifo_wr_water_level,
  output logic                      frame_done,
  output logic                      frame_err,
  output logic                      busy
);

  localparam int REMAIN_W = $clog2(FRAME_BEATS + 1);
  localparam int FLUSH_W  = $clog2(FLUSH_CYCLES);
  localparam int LEVEL_W  = FIFO_DEPTH_WIDTH + 1;

  localparam logic [LEVEL_W-1:0] FIFO_DEPTH = {1'b1, {FIFO_DEPTH_WIDTH{1'b0}}};

  typedef enum logic [2:0] {
    IDLE,
    FLUSH,
    WAIT_SPACE,
    REQ,
    DATA,
    DONE
  } state_t;

  state_t                state;
  state_t                state_next;
  logic [ADDR_WIDTH-1:0] addr;
  logic [REMAIN_W-1:0]   remain;
  logic                  pending;
  logic [8:0]            beat_cnt;
  logic [FLUSH_W-1:0]    flush_cnt;
  logic                  settled;
  logic                  err_next;

  logic [LEVEL_W-1:0]    space;
  logic [8:0]            len_calc;
  logic [8:0]            beat_inc;
  logic                  beat_last;
  logic [REMAIN_W-1:0]   remain_after;
  logic [ADDR_WIDTH-1:0] addr_after;
  logic                  space_ok;

  // Free FIFO space and the length of the next burst (clipped to what is left).
  assign space     = FIFO_DEPTH - fifo_wr_water_level;
  assign len_calc  = (32'(remain) >= 32'(BURST_LEN)) ? 9'(BURST_LEN) : 9'(remain);
  assign space_ok  = (32'(space) >= 32'(len_calc)) && !fifo_wr_full;

  // The held ddr_rd_len doubles as the length of the burst in flight.
  assign beat_inc     = beat_cnt + 9'd1;
  assign beat_last    = (state == DATA) && ddr_rd_valid && (beat_inc == ddr_rd_len);
  assign remain_after = remain - REMAIN_W'(ddr_rd_len);
  assign addr_after   = addr + (ADDR_WIDTH'(ddr_rd_len) * ADDR_WIDTH'(ADDR_STEP));

  // Returned beats go straight into the FIFO, but only while a burst is owed.
  assign fifo_wr_en   = ddr_rd_valid & (state == DATA);
  assign fifo_wr_data = ddr_rd_data;

  // Next-state decode; a restart seen mid-burst waits for the burst to finish.
  always_comb begin
    state_next = state;
    err_next   = 1'b0;
    case (state)
      IDLE: begin
        if (frame_start && enable) state_next = FLUSH;
      end
      FLUSH: begin
        if (flush_cnt == FLUSH_W'(FLUSH_CYCLES - 1)) state_next = WAIT_SPACE;
      end
      WAIT_SPACE: begin
        if (frame_start) begin
          state_next = FLUSH;
          err_next   = (remain != '0);
        end else if (remain == '0) begin
          state_next = DONE;
        end else if (!enable) begin
          state_next = IDLE;
        end else if (settled && space_ok) begin
          state_next = REQ;
        end
      end
      REQ: begin
        if (ddr_rd_ack) state_next = DATA;
      end
      DATA: begin
        if (beat_last) begin
          if (pending || frame_start) begin
            state_next = FLUSH;
            err_next   = (remain_after != '0);
          end else begin
            state_next = WAIT_SPACE;
          end
        end
      end
      DONE: begin
        if (frame_start) state_next = FLUSH;
        else             state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // State register, frame bookkeeping and registered outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      addr        <= '0;
      remain      <= '0;
      pending     <= 1'b0;
      beat_cnt    <= '0;
      flush_cnt   <= '0;
      settled     <= 1'b0;
      ddr_rd_req  <= 1'b0;
      ddr_rd_addr <= '0;
      ddr_rd_len  <= '0;
      fifo_rst    <= 1'b0;
      frame_done  <= 1'b0;
      frame_err   <= 1'b0;
      busy        <= 1'b0;
    end else begin
      state     <= state_next;
      settled   <= (state == WAIT_SPACE) && (state_next == WAIT_SPACE);
      flush_cnt <= (state == FLUSH) ? flush_cnt + 1'b1 : '0;

      if (state_next == FLUSH) begin
        addr   <= BASE_ADDR;
        remain <= REMAIN_W'(FRAME_BEATS);
      end else if (beat_last) begin
        addr   <= addr_after;
        remain <= remain_after;
      end

      if (state_next == FLUSH || state_next == IDLE) begin
        pending <= 1'b0;
      end else if (frame_start && (state == REQ || state == DATA)) begin
        pending <= 1'b1;
      end

      if (state == REQ) begin
        beat_cnt <= '0;
      end else if (fifo_wr_en) begin
        beat_cnt <= beat_inc;
      end

      if (state == WAIT_SPACE && state_next == REQ) begin
        ddr_rd_addr <= addr;
        ddr_rd_len  <= len_calc;
      end

      ddr_rd_req <= (state_next == REQ);
      fifo_rst   <= (state_next == FLUSH);
      frame_done <= (state_next == DONE);
      frame_err  <= err_next;
      busy       <= (state_next != IDLE);
    end
  end

endmodule
